// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the helper that sizes the shift counter.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;
    localparam logic [2:0] MODE_RSVD = 3'b111;

    // The counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/dff_en_arst.sv
// Enabled flop bank with active-low asynchronous reset to a parameterised value.
module dff_en_arst #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_o <= RESET_VAL;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/load/shift/rotate/clear with a saturating
// shift counter and a one-cycle done pulse for serializer use.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [2:0]                    mode,
    input  logic [WIDTH-1:0]              d,
    input  logic                          sin,
    output logic [WIDTH-1:0]              q,
    output logic [WIDTH-1:0]              qbar,
    output logic                          sout,
    output logic [cnt_width(WIDTH)-1:0]   cnt,
    output logic                          done
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q_d, q_q;
    logic [CW-1:0]    cnt_d, cnt_q;
    logic             done_d, done_q;
    logic             is_shift;
    logic             is_rearm;

    always_comb begin
        q_d      = q_q;
        is_shift = 1'b0;
        is_rearm = 1'b0;
        case (mode)
            MODE_LOAD: begin
                q_d      = d;
                is_rearm = 1'b1;
            end
            MODE_SHL: begin
                q_d      = {q_q[WIDTH-2:0], sin};
                is_shift = 1'b1;
            end
            MODE_SHR: begin
                q_d      = {sin, q_q[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            MODE_ROL: begin
                q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                is_shift = 1'b1;
            end
            MODE_ROR: begin
                q_d      = {q_q[0], q_q[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            MODE_CLR: begin
                q_d      = '0;
                is_rearm = 1'b1;
            end
            default: q_d = q_q;
        endcase
    end

    dff_en_arst #(
        .WIDTH    (WIDTH),
        .RESET_VAL(RESET_VAL)
    ) u_q_bank (
        .clk  (clk),
        .rst_n(rst),
        .en_i (en),
        .d_i  (q_d),
        .q_o  (q_q)
    );

    // done fires only on the WIDTH-1 -> WIDTH transition, so saturation never re-pulses.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (en) begin
            if (is_rearm) begin
                cnt_d = '0;
            end else if (is_shift && (cnt_q != CNT_MAX)) begin
                cnt_d  = cnt_q + 1'b1;
                done_d = (cnt_q == CNT_LAST);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
            if (en) begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign q    = q_q;
    assign qbar = ~q_q;
    assign sout = ((mode == MODE_SHL) || (mode == MODE_ROL)) ? q_q[WIDTH-1] : q_q[0];
    assign cnt  = cnt_q;
    assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg (WIDTH=8): directed scenarios plus random traffic,
// checked against an arithmetic model of the register, counter and done pulse.
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [2:0] mode = 3'b000;
    logic [7:0] d = 8'h00;
    logic       sin = 1'b0;
    logic [7:0] q, qbar;
    logic       sout;
    logic [3:0] cnt;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;

    int m_q    = 0;
    int m_cnt  = 0;
    int m_done = 0;

    univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .mode(mode),
        .d   (d),
        .sin (sin),
        .q   (q),
        .qbar(qbar),
        .sout(sout),
        .cnt (cnt),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".q"},    32'(q),    32'(m_q));
        check({tag, ".qbar"}, 32'(qbar), 32'(255 - m_q));
        check({tag, ".cnt"},  32'(cnt),  32'(m_cnt));
        check({tag, ".done"}, 32'(done), 32'(m_done));
    endtask

    task automatic model_reset();
        m_q = 0; m_cnt = 0; m_done = 0;
    endtask

    // Assert reset between edges and check that it lands without a clock.
    task automatic pulse_reset(input string tag);
        #2 rst = 1'b0;
        #1 model_reset();
        check_state(tag);
        #1 rst = 1'b1;
    endtask

    // One clock with the given inputs; model computed with plain integer arithmetic.
    task automatic cycle(input string tag, input bit e, input logic [2:0] md,
                         input logic [7:0] dd, input bit s);
        int exp_sout;
        int nq;
        en = e; mode = md; d = dd; sin = s;
        #1;
        exp_sout = (md == 3'd2 || md == 3'd4) ? (m_q / 128) : (m_q % 2);
        check({tag, ".sout"}, 32'(sout), 32'(exp_sout));
        nq = m_q;
        m_done = 0;
        if (e) begin
            case (md)
                3'd1: nq = dd;
                3'd2: nq = (m_q * 2 + s) % 256;
                3'd3: nq = m_q / 2 + s * 128;
                3'd4: nq = (m_q * 2) % 256 + m_q / 128;
                3'd5: nq = m_q / 2 + (m_q % 2) * 128;
                3'd6: nq = 0;
                default: nq = m_q;
            endcase
            if (md == 3'd1 || md == 3'd6) begin
                m_cnt = 0;
            end else if (md >= 3'd2 && md <= 3'd5 && m_cnt < 8) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == 8) m_done = 1;
            end
        end
        m_q = nq;
        @(posedge clk);
        #1;
        if (done === 1'b1) done_seen++;
        check_state(tag);
    endtask

    initial begin
        int r;
        logic [7:0] shl_exp [8];
        shl_exp = '{8'h4B, 8'h97, 8'h2F, 8'h5F, 8'hBF, 8'h7F, 8'hFF, 8'hFF};

        // 1: async reset mid-cycle at t=3
        #3 rst = 1'b0;
        #1 model_reset();
        check_state("rst_async");
        #4 rst = 1'b1;
        cycle("load5A", 1'b1, 3'd1, 8'h5A, 1'b0);
        check("load5A.q_const", 32'(q), 32'h5A);

        // 2: load / hold
        cycle("loadA5", 1'b1, 3'd1, 8'hA5, 1'b0);
        check("loadA5.qbar_const", 32'(qbar), 32'h5A);
        for (int i = 0; i < 3; i++) cycle("hold", 1'b1, 3'd0, 8'h00, 1'b0);

        // 3: shift left with sin=1
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            cycle("shl", 1'b1, 3'd2, 8'h00, 1'b1);
            check("shl.seq", 32'(q), 32'(shl_exp[i]));
        end
        check("shl.cnt8", 32'(cnt), 32'd8);
        cycle("shl9", 1'b1, 3'd2, 8'h00, 1'b1);
        check("shl.done_pulses", 32'(done_seen), 32'd1);

        // 4: rotate right
        cycle("load81", 1'b1, 3'd1, 8'h81, 1'b0);
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            cycle("ror", 1'b1, 3'd5, 8'h00, 1'b0);
            if (i == 0) check("ror.first", 32'(q), 32'hC0);
        end
        check("ror.back", 32'(q), 32'h81);
        check("ror.done_pulses", 32'(done_seen), 32'd1);

        // 5: enable gating, clear, reserved
        cycle("en0", 1'b0, 3'd1, 8'h3C, 1'b0);
        cycle("clr", 1'b1, 3'd6, 8'h3C, 1'b0);
        cycle("rsvd", 1'b1, 3'd7, 8'h3C, 1'b1);

        // 6: reset mid-operation then serialise F0
        cycle("pre", 1'b1, 3'd1, 8'h6D, 1'b0);
        for (int i = 0; i < 3; i++) cycle("shl3", 1'b1, 3'd2, 8'h00, 1'b1);
        pulse_reset("rst_mid");
        cycle("loadF0", 1'b1, 3'd1, 8'hF0, 1'b0);
        done_seen = 0;
        for (int i = 0; i < 8; i++) cycle("serF0", 1'b1, 3'd2, 8'h00, 1'b0);
        check("serF0.q", 32'(q), 32'h00);
        check("serF0.done_pulses", 32'(done_seen), 32'd1);

        // Random traffic, including occasional reset and load-on-count edges
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                pulse_reset("rnd_rst");
            end else begin
                cycle("rnd", ($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)),
                      8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
